// File: rtl/result_framer_if.sv
// result_framer_if
//   Bundles the two buses of the result framer:
//     upstream read bus : rd_sop (request), rd_vld, rd_data[15:0], rd_eop
//     downstream stream : out_valid, out_ready, out_data[7:0], out_last
//   master : the framer side (drives rd_sop and the byte stream)
//   slave  : the store/consumer side (drives read words and out_ready)
interface result_framer_if;
  logic        rd_sop;
  logic        rd_vld;
  logic [15:0] rd_data;
  logic        rd_eop;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;

  modport master (
    output rd_sop, out_valid, out_data, out_last,
    input  rd_vld, rd_data, rd_eop, out_ready
  );

  modport slave (
    input  rd_sop, out_valid, out_data, out_last,
    output rd_vld, rd_data, rd_eop, out_ready
  );
endinterface

// File: rtl/result_framer.sv
// result_framer
//   On start, requests one 8-word packet from an upstream result store,
//   captures it, and emits an 18-byte frame: header, 16 data bytes
//   (high byte first), then a modulo-256 checksum of the data bytes.
//   Malformed packets and capture timeouts set a sticky frame_err.
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   start     : frame request, accepted only when idle
//   bus       : result_framer_if.master (read bus + byte stream)
//   busy      : high whenever not idle
//   frame_err : sticky error, cleared by rst or an accepted start
//   frame_cnt : completed-frame counter, wraps
module result_framer #(
  parameter int          TIMEOUT = 16,
  parameter logic [7:0]  HDR     = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  result_framer_if.master       bus,
  output logic                  busy,
  output logic                  frame_err,
  output logic [7:0]            frame_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, CAPTURE, SEND} state_t;

  state_t        state, state_nxt;
  logic [15:0]   word_buf [8];
  logic [2:0]    wcnt;
  logic [TW-1:0] tcnt;
  logic [4:0]    idx, idx_nxt;
  logic [7:0]    csum;
  logic          abort;
  logic          xfer;

  // Frame byte at index i: 0 = header, 1..16 = data (high byte first), 17 = checksum.
  function automatic logic [7:0] byte_at(input logic [4:0] i);
    logic [3:0]  j;
    logic [15:0] w;
    j = 4'(i - 5'd1);
    w = word_buf[j[3:1]];
    if (i == 5'd0)
      byte_at = HDR;
    else if (i == 5'd17)
      byte_at = csum;
    else
      byte_at = j[0] ? w[7:0] : w[15:8];
  endfunction

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    abort     = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = REQ;
      REQ:  state_nxt = CAPTURE;
      CAPTURE: begin
        if (bus.rd_vld && bus.rd_eop && wcnt == 3'd7) begin
          state_nxt = SEND;
          idx_nxt   = 5'd0;
        end else if (bus.rd_eop || (bus.rd_vld && wcnt == 3'd7) ||
                     tcnt == TW'(TIMEOUT - 1)) begin
          // Early/late end-of-packet or no completion in time: drop the packet.
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      SEND: begin
        if (bus.out_valid && bus.out_ready) begin
          xfer = 1'b1;
          if (idx == 5'd17) begin
            state_nxt = IDLE;
            idx_nxt   = 5'd0;
          end else begin
            idx_nxt = idx + 5'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and registered outputs; outputs are loaded from the next state so
  // they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= 5'd0;
      wcnt          <= 3'd0;
      tcnt          <= '0;
      bus.rd_sop    <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= 8'd0;
      busy          <= 1'b0;
      frame_err     <= 1'b0;
      frame_cnt     <= 8'd0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      bus.rd_sop    <= (state_nxt == REQ);
      bus.out_valid <= (state_nxt == SEND);
      bus.out_last  <= (state_nxt == SEND) && (idx_nxt == 5'd17);
      bus.out_data  <= (state_nxt == SEND) ? byte_at(idx_nxt) : 8'd0;
      busy          <= (state_nxt != IDLE);

      if (state == IDLE && start)
        frame_err <= 1'b0;
      else if (abort)
        frame_err <= 1'b1;

      if (xfer && idx == 5'd17)
        frame_cnt <= frame_cnt + 8'd1;

      if (state == CAPTURE) begin
        tcnt <= tcnt + TW'(1);
        if (bus.rd_vld) wcnt <= wcnt + 3'd1;
      end else begin
        tcnt <= '0;
        wcnt <= 3'd0;
      end
    end
  end

  // Capture datapath: word storage and running checksum.
  always_ff @(posedge clk) begin
    if (state == REQ)
      csum <= 8'd0;
    else if (state == CAPTURE && bus.rd_vld)
      csum <= csum + bus.rd_data[15:8] + bus.rd_data[7:0];
    if (state == CAPTURE && bus.rd_vld)
      word_buf[wcnt] <= bus.rd_data;
  end

endmodule

// File: tb/tb_result_framer.sv
module tb_result_framer;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy;
  logic       frame_err;
  logic [7:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] words [8];
  logic [8:0]  sb [$];   // {last, data}

  logic       pv, pr, pl;
  logic [7:0] pd;

  result_framer_if bus();

  result_framer #(.TIMEOUT(16), .HDR(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every accepted byte is popped and compared; stalled bytes must hold.
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (bus.out_valid && pv && !pr) begin
        chk("stall_data", 16'(bus.out_data), 16'(pd));
        chk("stall_last", 16'(bus.out_last), 16'(pl));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_byte", 16'(bus.out_data), 16'hDEAD);
        end else begin
          logic [8:0] e;
          e = sb.pop_front();
          chk("byte", 16'(bus.out_data), 16'(e[7:0]));
          chk("last", 16'(bus.out_last), 16'(e[8]));
        end
      end
      pv = bus.out_valid;
      pr = bus.out_ready;
      pd = bus.out_data;
      pl = bus.out_last;
    end
  end

  task automatic start_req();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("sop_after_start", 16'(bus.rd_sop), 16'd1);
    chk("busy_after_start", 16'(busy), 16'd1);
  endtask

  // Drives n words with rd_eop on the last; full packets push the expected frame.
  task automatic send_words(input int n);
    logic [7:0] sum;
    if (n == 8) begin
      sum = 8'd0;
      sb.push_back({1'b0, 8'hA5});
      for (int k = 0; k < 8; k++) begin
        sb.push_back({1'b0, words[k][15:8]});
        sb.push_back({1'b0, words[k][7:0]});
        sum = sum + words[k][15:8] + words[k][7:0];
      end
      sb.push_back({1'b1, sum});
    end
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (k == 0) chk("sop_one_cycle", 16'(bus.rd_sop), 16'd0);
      bus.rd_vld  = 1'b1;
      bus.rd_data = words[k];
      bus.rd_eop  = (k == n - 1);
    end
    @(posedge clk); #1;
    bus.rd_vld  = 1'b0;
    bus.rd_eop  = 1'b0;
    bus.rd_data = 16'd0;
  endtask

  // Counts out_valid cycles until the frame ends (bounded).
  task automatic drain(input bit toggle, output int n);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      if (!bus.out_valid) break;
      n++;
      @(posedge clk); #1;
      if (toggle) bus.out_ready = ~bus.out_ready;
    end
    bus.out_ready = 1'b1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    bus.rd_vld = 1'b0;
    bus.rd_eop = 1'b0;
    bus.rd_data = 16'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sop", 16'(bus.rd_sop), 16'd0);
    chk("rst_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_last", 16'(bus.out_last), 16'd0);
    chk("rst_data", 16'(bus.out_data), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_err", 16'(frame_err), 16'd0);
    chk("rst_cnt", 16'(frame_cnt), 16'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Incrementing words, out_ready held high.
    for (int k = 0; k < 8; k++) words[k] = {8'(2 * k + 1), 8'(2 * k + 2)};
    start_req();
    send_words(8);
    chk("first_valid_A", 16'(bus.out_valid), 16'd1);
    drain(1'b0, n);
    chk("send_cycles_A", 16'(n), 16'd18);
    chk("cnt_A", 16'(frame_cnt), 16'd1);
    chk("busy_end_A", 16'(busy), 16'd0);
    chk("sb_empty_A", 16'(sb.size()), 16'd0);

    // Same data, out_ready toggling every cycle.
    start_req();
    send_words(8);
    chk("first_valid_B", 16'(bus.out_valid), 16'd1);
    drain(1'b1, n);
    chk("send_cycles_B", 16'(n), 16'd35);
    chk("cnt_B", 16'(frame_cnt), 16'd2);
    chk("sb_empty_B", 16'(sb.size()), 16'd0);

    // Short packet: rd_eop on the 5th word.
    start_req();
    send_words(5);
    chk("short_err", 16'(frame_err), 16'd1);
    chk("short_busy", 16'(busy), 16'd0);
    chk("short_valid", 16'(bus.out_valid), 16'd0);
    @(posedge clk); #1;
    chk("short_valid2", 16'(bus.out_valid), 16'd0);

    // Next start clears the error, then no data arrives: timeout.
    start_req();
    chk("err_cleared", 16'(frame_err), 16'd0);
    @(posedge clk); #1;
    repeat (15) @(posedge clk);
    #1;
    chk("to_busy_before", 16'(busy), 16'd1);
    chk("to_err_before", 16'(frame_err), 16'd0);
    @(posedge clk); #1;
    chk("to_err", 16'(frame_err), 16'd1);
    chk("to_busy", 16'(busy), 16'd0);

    // All-ones data over 256 back-to-back frames.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) words[k] = 16'hFFFF;
    for (int i = 0; i < 256; i++) begin
      start_req();
      send_words(8);
      drain(1'b0, n);
      if (i == 0) chk("send_cycles_ff", 16'(n), 16'd18);
      if (i == 254) chk("cnt_255", 16'(frame_cnt), 16'd255);
    end
    chk("cnt_wrap", 16'(frame_cnt), 16'd0);
    chk("sb_empty_ff", 16'(sb.size()), 16'd0);

    // Reset at byte index 9.
    for (int k = 0; k < 8; k++) words[k] = 16'($urandom);
    start_req();
    send_words(8);
    repeat (9) @(posedge clk);
    #1;
    chk("idx9_byte", 16'(bus.out_data), 16'(words[4][15:8]));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", 16'(bus.out_valid), 16'd0);
    chk("mid_rst_last", 16'(bus.out_last), 16'd0);
    chk("mid_rst_data", 16'(bus.out_data), 16'd0);
    chk("mid_rst_busy", 16'(busy), 16'd0);
    chk("mid_rst_sop", 16'(bus.rd_sop), 16'd0);
    chk("mid_rst_err", 16'(frame_err), 16'd0);
    chk("mid_rst_cnt", 16'(frame_cnt), 16'd0);
    sb.delete();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_valid", 16'(bus.out_valid), 16'd0);
    for (int k = 0; k < 8; k++) words[k] = 16'($urandom);
    start_req();
    send_words(8);
    drain(1'b0, n);
    chk("send_cycles_R", 16'(n), 16'd18);
    chk("cnt_R", 16'(frame_cnt), 16'd1);
    chk("sb_empty_R", 16'(sb.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
